// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_sequencer
// Brief    : Takes interrupt requests, pushes the return PC on a LIFO and
//            redirects fetch; restores the PC and acknowledges on reti.
// Revision : 1.0
// ============================================================================
module interrupt_sequencer #(
    parameter int AW      = 10,
    parameter int DEPTH_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_interruption,
    input  logic [AW-1:0]      dir_in,
    input  logic [AW-1:0]      pc_current,
    input  logic               reti,
    output logic               pc_load,
    output logic [AW-1:0]      pc_target,
    output logic               s_finished,
    output logic               in_service,
    output logic [DEPTH_W:0]   depth,
    output logic               overflow,
    output logic               underflow
);

    localparam int               DEPTH      = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] DEPTH_FULL = (DEPTH_W+1)'(DEPTH);
    localparam logic [DEPTH_W:0] ONE        = (DEPTH_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_SERVICE = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               s_int_q;
    logic               pend_q, pend_d;
    logic [AW-1:0]      pend_vec_q, pend_vec_d;
    logic               pc_load_q, pc_load_d;
    logic [AW-1:0]      pc_target_q, pc_target_d;
    logic               s_fin_q, s_fin_d;
    logic [DEPTH_W:0]   depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [AW-1:0]      stack_q [DEPTH];

    logic               req;
    logic               have_req;
    logic [AW-1:0]      take_vec;
    logic [DEPTH_W-1:0] top_idx;
    logic               push;
    logic               take;
    logic               defer;

    assign req      = s_interruption & ~s_int_q;
    assign have_req = req | pend_q;
    // A pending request is older than a fresh edge, so it wins the vector.
    assign take_vec = pend_q ? pend_vec_q : dir_in;
    assign top_idx  = DEPTH_W'(depth_q - ONE);

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_vec_d  = pend_vec_q;
        pc_load_d   = 1'b0;
        pc_target_d = pc_target_q;
        s_fin_d     = 1'b0;
        depth_d     = depth_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        push        = 1'b0;
        take        = 1'b0;
        defer       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reti) begin
                    unf_d = 1'b1;
                    defer = 1'b1;
                end else if (have_req) begin
                    take = 1'b1;
                end
            end
            ST_ENTER: begin
                state_d = ST_SERVICE;
                defer   = 1'b1;
            end
            ST_SERVICE: begin
                if (reti) begin
                    pc_target_d = stack_q[top_idx];
                    pc_load_d   = 1'b1;
                    s_fin_d     = 1'b1;
                    depth_d     = depth_q - ONE;
                    state_d     = ST_RETURN;
                    defer       = 1'b1;
                end else if (have_req) begin
                    if (depth_q == DEPTH_FULL) begin
                        ovf_d  = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            ST_RETURN: begin
                state_d = (depth_q == '0) ? ST_IDLE : ST_SERVICE;
                defer   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            push        = 1'b1;
            pc_target_d = take_vec;
            pc_load_d   = 1'b1;
            depth_d     = depth_q + ONE;
            pend_d      = 1'b0;
            state_d     = ST_ENTER;
        end

        // Only the first deferred request is remembered; later edges are dropped.
        if (defer && req && !pend_q) begin
            pend_d     = 1'b1;
            pend_vec_d = dir_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_int_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_vec_q  <= '0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            s_fin_q     <= 1'b0;
            depth_q     <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_int_q     <= s_interruption;
            pend_q      <= pend_d;
            pend_vec_q  <= pend_vec_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
            s_fin_q     <= s_fin_d;
            depth_q     <= depth_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stack_q[depth_q[DEPTH_W-1:0]] <= pc_current;
        end
    end

    assign pc_load    = pc_load_q;
    assign pc_target  = pc_target_q;
    assign s_finished = s_fin_q;
    assign depth      = depth_q;
    assign in_service = (depth_q != '0);
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_sequencer
// Brief    : Directed and random stimulus against a queue-based return model.
// Revision : 1.0
// ============================================================================
module tb_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_interruption = 1'b0;
    logic [9:0] dir_in = '0;
    logic [9:0] pc_current = '0;
    logic       reti = 1'b0;
    logic       pc_load;
    logic [9:0] pc_target;
    logic       s_finished;
    logic       in_service;
    logic [2:0] depth;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    // Reference model: a plain queue of return addresses; the cycle after any
    // redirect is a settle cycle in which nothing is taken or returned.
    logic [9:0] m_stk[$];
    logic       m_pend, m_prev_s, m_settle, m_load, m_fin, m_ovf, m_unf;
    logic [9:0] m_pvec, m_tgt;

    interrupt_sequencer #(.AW(10), .DEPTH_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .s_interruption (s_interruption),
        .dir_in         (dir_in),
        .pc_current     (pc_current),
        .reti           (reti),
        .pc_load        (pc_load),
        .pc_target      (pc_target),
        .s_finished     (s_finished),
        .in_service     (in_service),
        .depth          (depth),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    task automatic model(input logic r, input logic s, input logic [9:0] d,
                         input logic [9:0] pc, input logic rt);
        logic       rq;
        logic       dfr;
        logic [9:0] v;
        if (r) begin
            m_stk.delete();
            m_pend = 0; m_pvec = '0; m_prev_s = 0; m_settle = 0;
            m_load = 0; m_fin = 0; m_tgt = '0; m_ovf = 0; m_unf = 0;
            return;
        end
        rq = s & ~m_prev_s;
        m_prev_s = s;
        m_load = 0;
        m_fin  = 0;
        dfr    = 0;
        if (m_settle) begin
            dfr = 1;
        end else if (rt) begin
            if (m_stk.size() == 0) m_unf = 1;
            else begin
                m_tgt  = m_stk.pop_back();
                m_load = 1;
                m_fin  = 1;
            end
            dfr = 1;
        end else if (rq || m_pend) begin
            v = m_pend ? m_pvec : d;
            m_pend = 0;
            if (m_stk.size() == 4) m_ovf = 1;
            else begin
                m_stk.push_back(pc);
                m_tgt  = v;
                m_load = 1;
            end
        end
        if (dfr && rq && !m_pend) begin
            m_pend = 1;
            m_pvec = d;
        end
        m_settle = m_load;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("pc_load",    int'(pc_load),    int'(m_load));
        chk("pc_target",  int'(pc_target),  int'(m_tgt));
        chk("s_finished", int'(s_finished), int'(m_fin));
        chk("depth",      int'(depth),      m_stk.size());
        chk("in_service", int'(in_service), int'(m_stk.size() != 0));
        chk("overflow",   int'(overflow),   int'(m_ovf));
        chk("underflow",  int'(underflow),  int'(m_unf));
    endtask

    task automatic step(input logic r, input logic s, input logic [9:0] d,
                        input logic [9:0] pc, input logic rt);
        reset = r; s_interruption = s; dir_in = d; pc_current = pc; reti = rt;
        @(posedge clk);
        model(r, s, d, pc, rt);
        #1;
        check_all();
    endtask

    initial begin
        logic s_r;
        // Reset state
        step(1, 0, 10'h000, 10'h000, 0);
        step(1, 0, 10'h000, 10'h000, 0);
        chk("rst_depth", int'(depth), 0);
        chk("rst_target", int'(pc_target), 0);

        // 1: single entry and return
        step(0, 0, 10'h012, 10'h0A5, 0);
        step(0, 1, 10'h012, 10'h0A5, 0);
        chk("t1_load", int'(pc_load), 1);
        chk("t1_tgt", int'(pc_target), 10'h012);
        chk("t1_depth", int'(depth), 1);
        step(0, 0, 10'h000, 10'h012, 0);
        step(0, 0, 10'h000, 10'h013, 0);
        step(0, 0, 10'h000, 10'h014, 1);
        chk("t1_ret_tgt", int'(pc_target), 10'h0A5);
        chk("t1_fin", int'(s_finished), 1);
        chk("t1_ret_depth", int'(depth), 0);
        step(0, 0, 10'h000, 10'h0A5, 0);
        chk("t1_fin_pulse", int'(s_finished), 0);

        // 2: nesting two levels
        step(0, 1, 10'h3FB, 10'h100, 0);
        step(0, 0, 10'h000, 10'h3FB, 0);
        step(0, 1, 10'h3FC, 10'h200, 0);
        chk("t2_depth2", int'(depth), 2);
        step(0, 0, 10'h000, 10'h3FC, 0);
        step(0, 0, 10'h000, 10'h3FD, 1);
        chk("t2_ret1", int'(pc_target), 10'h200);
        step(0, 0, 10'h000, 10'h200, 0);
        step(0, 0, 10'h000, 10'h201, 1);
        chk("t2_ret2", int'(pc_target), 10'h100);
        chk("t2_insvc", int'(in_service), 0);
        step(0, 0, 10'h000, 10'h100, 0);

        // 3: overflow on fifth nested request
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 10'(10'h300 + i), 10'(10'h010 + i), 0);
            step(0, 0, 10'h000, 10'h050, 0);
        end
        chk("t3_ovf", int'(overflow), 1);
        chk("t3_depth", int'(depth), 4);
        step(1, 0, 10'h000, 10'h000, 0);

        // 4: underflow
        step(0, 0, 10'h000, 10'h000, 1);
        chk("t4_unf", int'(underflow), 1);
        chk("t4_noload", int'(pc_load), 0);
        step(1, 0, 10'h000, 10'h000, 0);

        // 5: collision of request and reti at depth 1
        step(0, 1, 10'h011, 10'h077, 0);
        step(0, 0, 10'h000, 10'h011, 0);
        step(0, 0, 10'h000, 10'h012, 0);
        step(0, 1, 10'h3FD, 10'h013, 1);
        chk("t5_ret", int'(pc_target), 10'h077);
        step(0, 1, 10'h000, 10'h077, 0);
        step(0, 1, 10'h000, 10'h077, 0);
        chk("t5_pend_tgt", int'(pc_target), 10'h3FD);
        chk("t5_pend_depth", int'(depth), 1);

        // 6: held level gives one entry; reset in service
        step(1, 0, 10'h000, 10'h000, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 10'h155, 10'h0AA, 0);
        chk("t6_single", int'(depth), 1);
        step(1, 1, 10'h155, 10'h0AA, 0);
        chk("t6_rst_depth", int'(depth), 0);
        chk("t6_rst_tgt", int'(pc_target), 0);

        // Random phase
        s_r = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) s_r = ~s_r;
            step(($urandom_range(0, 199) == 0), s_r, 10'($urandom),
                 10'($urandom), ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
